// File: rtl/div_bus_pkg.sv
// Shared types and constants for the divider bus host: FSM states, byte-order indices,
// word/byte widths and a byte-select helper.
package div_bus_pkg;

    localparam int unsigned WordW = 16;
    localparam int unsigned ByteW = 8;

    // Byte order on the wire: word A high, word A low, word B high, word B low.
    // TX: A = dividend, B = divisor. RX: A = quotient, B = remainder.
    localparam logic [1:0] IdxAHi = 2'd0;
    localparam logic [1:0] IdxALo = 2'd1;
    localparam logic [1:0] IdxBHi = 2'd2;
    localparam logic [1:0] IdxBLo = 2'd3;
    localparam logic [1:0] IdxLast = IdxBLo;

    typedef enum logic [2:0] {
        StIdle,
        StTxSetup,
        StTxStrobe,
        StTxGap,
        StRxWait,
        StRxAck,
        StRxGap,
        StResp
    } state_e;

    function automatic logic [ByteW-1:0] pick_byte(input logic [WordW-1:0] word_a,
                                                   input logic [WordW-1:0] word_b,
                                                   input logic [1:0]       idx);
        logic [ByteW-1:0] b;
        unique case (idx)
            IdxAHi:  b = word_a[15:8];
            IdxALo:  b = word_a[7:0];
            IdxBHi:  b = word_b[15:8];
            default: b = word_b[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/div_bus_strobe_timer.sv
// Loadable down-counter; done is high while the count is zero, so loading N-1
// yields a phase lasting N cycles.
module div_bus_strobe_timer #(
    parameter int unsigned Width = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    output logic             done
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/div_bus_host.sv
// Host-side byte-bus master for the restoring divider: serialises operands, collects results.
// Optional feature: `define DIV_BUS_HOST_ZERO_CHECK_EN answers divide-by-zero locally.
module div_bus_host
    import div_bus_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WordW-1:0] req_dividend,
    input  logic [WordW-1:0] req_divisor,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WordW-1:0] rsp_quotient,
    output logic [WordW-1:0] rsp_remainder,
    output logic             rsp_div_zero,
    output logic [ByteW-1:0] bus_out,
    output logic             start_data,
    input  logic             ready_to_accept,
    input  logic [ByteW-1:0] bus_in,
    input  logic             out_buff_full,
    output logic             received_data,
    output logic             busy
);

    localparam int unsigned MaxCycles = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam logic [TimerW-1:0] StrobeLoad = TimerW'(STROBE_CYCLES - 1);
    localparam logic [TimerW-1:0] GapLoad    = TimerW'(GAP_CYCLES - 1);

    state_e             state_q, state_d;
    logic [WordW-1:0]   dividend_q, divisor_q;
    logic [WordW-1:0]   quot_q, rem_q;
    logic [1:0]         idx_q;
    logic               init_q;
    logic               accept;
    logic               zero_req;
    logic               timer_load;
    logic [TimerW-1:0]  timer_val;
    logic               timer_done;

    assign accept = req_valid & req_ready;

`ifdef DIV_BUS_HOST_ZERO_CHECK_EN
    logic div_zero_q;

    assign zero_req     = (req_divisor == '0);
    assign rsp_div_zero = div_zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_zero_q <= 1'b0;
        end else if (state_q == StIdle && accept) begin
            div_zero_q <= zero_req;
        end
    end
`else
    assign zero_req     = 1'b0;
    assign rsp_div_zero = 1'b0;
`endif

    div_bus_strobe_timer #(
        .Width (TimerW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (accept) state_d = zero_req ? StResp : StTxSetup;
            StTxSetup:  if (ready_to_accept) state_d = StTxStrobe;
            StTxStrobe: if (timer_done) state_d = StTxGap;
            StTxGap:    if (timer_done) state_d = (idx_q == IdxLast) ? StRxWait : StTxSetup;
            StRxWait:   if (out_buff_full) state_d = StRxAck;
            StRxAck:    if (timer_done) state_d = StRxGap;
            StRxGap:    if (timer_done) state_d = (idx_q == IdxLast) ? StResp : StRxWait;
            StResp:     if (rsp_ready) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        start_data    = (state_q == StTxStrobe);
        received_data = (state_q == StRxAck);
        rsp_valid     = (state_q == StResp);
        busy          = (state_q != StIdle);
        // Held low through reset and for the first cycle after release.
        req_ready     = (state_q == StIdle) & init_q;
        bus_out       = '0;
        if (state_q == StTxSetup || state_q == StTxStrobe || state_q == StTxGap) begin
            bus_out = pick_byte(dividend_q, divisor_q, idx_q);
        end
        timer_load = 1'b0;
        timer_val  = StrobeLoad;
        unique case (state_q)
            StTxSetup:  timer_load = ready_to_accept;
            StRxWait:   timer_load = out_buff_full;
            StTxStrobe, StRxAck: begin
                timer_load = timer_done;
                timer_val  = GapLoad;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q     <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            idx_q      <= '0;
        end else begin
            init_q <= 1'b1;
            if (state_q == StIdle && accept) begin
                dividend_q <= req_dividend;
                divisor_q  <= req_divisor;
                idx_q      <= '0;
                if (zero_req) begin
                    quot_q <= '1;
                    rem_q  <= req_dividend;
                end
            end
            if (state_q == StRxWait && out_buff_full) begin
                unique case (idx_q)
                    IdxAHi:  quot_q[15:8] <= bus_in;
                    IdxALo:  quot_q[7:0]  <= bus_in;
                    IdxBHi:  rem_q[15:8]  <= bus_in;
                    default: rem_q[7:0]   <= bus_in;
                endcase
            end
            if ((state_q == StTxGap || state_q == StRxGap) && timer_done) begin
                idx_q <= (idx_q == IdxLast) ? '0 : idx_q + 2'd1;
            end
        end
    end

    assign rsp_quotient  = quot_q;
    assign rsp_remainder = rem_q;

endmodule

// File: tb/tb_div_bus_host.sv
// Self-checking bench for div_bus_host with a behavioural divider model on the byte bus.
module tb_div_bus_host;

    localparam int STROBE = 2;
    localparam int GAP    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_dividend = '0;
    logic [15:0] req_divisor = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_quotient;
    logic [15:0] rsp_remainder;
    logic        rsp_div_zero;
    logic [7:0]  bus_out;
    logic        start_data;
    logic        ready_to_accept = 1'b1;
    logic [7:0]  bus_in = '0;
    logic        out_buff_full = 1'b0;
    logic        received_data;
    logic        busy;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    div_bus_host #(
        .STROBE_CYCLES (STROBE),
        .GAP_CYCLES    (GAP)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_dividend    (req_dividend),
        .req_divisor     (req_divisor),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_quotient    (rsp_quotient),
        .rsp_remainder   (rsp_remainder),
        .rsp_div_zero    (rsp_div_zero),
        .bus_out         (bus_out),
        .start_data      (start_data),
        .ready_to_accept (ready_to_accept),
        .bus_in          (bus_in),
        .out_buff_full   (out_buff_full),
        .received_data   (received_data),
        .busy            (busy)
    );

    // Divider model state and bus monitors.
    logic [7:0] tx_q[$];
    logic [7:0] tx_log[$];
    logic [7:0] rsp_q[$];
    logic [7:0] last_byte = '0;
    logic       prev_start = 1'b0, prev_rd = 1'b0, responding = 1'b0;
    int start_len = 0, rd_len = 0, hold_cnt = 0, stall_cnt = 0, stall_at_byte = -1;
    int start_pulses = 0, start_bad_len = 0, rd_pulses = 0, rd_bad_len = 0, bus_unstable = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            tx_q.delete();
            rsp_q.delete();
            prev_start = 1'b0;
            prev_rd = 1'b0;
            responding = 1'b0;
            hold_cnt = 0;
            stall_cnt = 0;
            out_buff_full = 1'b0;
            bus_in = '0;
            ready_to_accept = 1'b1;
        end else begin
            if (stall_cnt > 0) stall_cnt--;
            if (start_data) begin
                if (!prev_start) begin
                    tx_q.push_back(bus_out);
                    tx_log.push_back(bus_out);
                    last_byte = bus_out;
                    start_len = 0;
                    if (tx_q.size() == stall_at_byte) begin
                        stall_cnt = 10;
                        stall_at_byte = -1;
                    end
                end else if (bus_out !== last_byte) begin
                    bus_unstable++;
                end
                start_len++;
                hold_cnt = GAP;
            end else begin
                if (prev_start) begin
                    start_pulses++;
                    if (start_len != STROBE) start_bad_len++;
                end
                if (hold_cnt > 0) begin
                    if (bus_out !== last_byte) bus_unstable++;
                    hold_cnt--;
                end
            end
            prev_start = start_data;
            ready_to_accept = (stall_cnt == 0);

            if (received_data) begin
                if (!prev_rd) rd_len = 0;
                rd_len++;
            end else if (prev_rd) begin
                rd_pulses++;
                if (rd_len != STROBE) rd_bad_len++;
            end
            prev_rd = received_data;

            if (!responding && tx_q.size() == 4) begin
                logic [15:0] a, b, q, r;
                a = {tx_q[0], tx_q[1]};
                b = {tx_q[2], tx_q[3]};
                if (b == 16'd0) begin
                    q = 16'hFFFF;
                    r = a;
                end else begin
                    q = a / b;
                    r = a % b;
                end
                tx_q.delete();
                rsp_q.push_back(q[15:8]);
                rsp_q.push_back(q[7:0]);
                rsp_q.push_back(r[15:8]);
                rsp_q.push_back(r[7:0]);
                responding = 1'b1;
            end
            if (responding) begin
                if (out_buff_full && received_data) begin
                    void'(rsp_q.pop_front());
                    out_buff_full = 1'b0;
                end else if (!out_buff_full && !received_data && rsp_q.size() > 0) begin
                    out_buff_full = 1'b1;
                    bus_in = rsp_q[0];
                end
                if (rsp_q.size() == 0 && !out_buff_full) responding = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        tx_log.delete();
        start_pulses = 0;
        start_bad_len = 0;
        rd_pulses = 0;
        rd_bad_len = 0;
        bus_unstable = 0;
    endtask

    task automatic send_req(input logic [15:0] a, input logic [15:0] b, output bit ok);
        ok = 1'b0;
        req_dividend = a;
        req_divisor = b;
        req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok, output logic [15:0] q, output logic [15:0] r,
                            output logic dz);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        q = rsp_quotient;
        r = rsp_remainder;
        dz = rsp_div_zero;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // Full transaction with checks of bytes sent, result and strobe shapes.
    task automatic run_txn(input string name, input logic [15:0] a, input logic [15:0] b);
        bit ok_req, ok_rsp;
        logic [15:0] q, r, eq, er;
        logic dz;
        clear_log();
        send_req(a, b, ok_req);
        wait_rsp(ok_rsp, q, r, dz);
        eq = (b == 16'd0) ? 16'hFFFF : a / b;
        er = (b == 16'd0) ? a : a % b;
        compared++;
        if (!ok_req || !ok_rsp) begin
            mismatched++;
            $display("FAIL %s handshake: req_ok=%0d rsp_ok=%0d required 1/1", name, ok_req, ok_rsp);
        end
        compared++;
        if (tx_log.size() != 4 || {tx_log[0], tx_log[1], tx_log[2], tx_log[3]} !== {a, b}) begin
            mismatched++;
            $display("FAIL %s tx_bytes: got %0d bytes, operands %h/%h", name, tx_log.size(), a, b);
        end
        compared++;
        if ({q, r, dz} !== {eq, er, 1'b0}) begin
            mismatched++;
            $display("FAIL %s result: got q=%h r=%h dz=%b required q=%h r=%h dz=0",
                     name, q, r, dz, eq, er);
        end
        consume();
        compared++;
        if (rsp_valid !== 1'b0 || start_pulses != 4 || start_bad_len != 0 ||
            bus_unstable != 0) begin
            mismatched++;
            $display("FAIL %s tx_shape: rsp_valid=%b pulses=%0d badlen=%0d unstable=%0d required 0/4/0/0",
                     name, rsp_valid, start_pulses, start_bad_len, bus_unstable);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        compared++;
        if ({req_ready, rsp_valid, busy, start_data, received_data, bus_out, rsp_div_zero} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b sd=%b rd=%b bus=%h required all 0",
                     req_ready, rsp_valid, busy, start_data, received_data, bus_out);
        end
        rst_n = 1'b1;
        tick();
        compared++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_release: req_ready=%b busy=%b required 1/0", req_ready, busy);
        end
    endtask

    task automatic test_basic();
        run_txn("basic_25_5", 16'd25, 16'd5);
    endtask

    task automatic test_rx_acks();
        run_txn("div_1000_7", 16'd1000, 16'd7);
        compared++;
        if (rd_pulses != 4 || rd_bad_len != 0) begin
            mismatched++;
            $display("FAIL rx_acks: pulses=%0d badlen=%0d required 4/0", rd_pulses, rd_bad_len);
        end
    endtask

    task automatic test_tx_stall();
        bit ok_req, ok_rsp, seen;
        logic [15:0] q, r;
        logic dz;
        clear_log();
        stall_at_byte = 2;
        send_req(16'h1234, 16'h0305, ok_req);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (tx_log.size() >= 2) seen = 1'b1;
            else tick();
        end
        for (int i = 0; i < 30 && stall_cnt != 0; i++) tick();
        compared++;
        if (!seen || tx_log.size() != 2 || start_data !== 1'b0 || bus_out !== 8'h03) begin
            mismatched++;
            $display("FAIL tx_stall: bytes=%0d start=%b bus=%h required 2/0/03",
                     tx_log.size(), start_data, bus_out);
        end
        wait_rsp(ok_rsp, q, r, dz);
        compared++;
        if (!ok_req || !ok_rsp || q !== 16'h1234 / 16'h0305 || r !== 16'h1234 % 16'h0305) begin
            mismatched++;
            $display("FAIL tx_stall_result: got q=%h r=%h required q=%h r=%h",
                     q, r, 16'h1234 / 16'h0305, 16'h1234 % 16'h0305);
        end
        consume();
    endtask

    task automatic test_backpressure();
        bit ok_req, ok_rsp, stable;
        logic [15:0] q, r;
        logic dz;
        logic [15:0] a, b;
        a = 16'($urandom);
        b = 16'($urandom_range(1, 300));
        clear_log();
        send_req(a, b, ok_req);
        wait_rsp(ok_rsp, q, r, dz);
        stable = ok_req && ok_rsp;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_quotient !== a / b ||
                rsp_remainder !== a % b) stable = 1'b0;
        end
        compared++;
        if (!stable) begin
            mismatched++;
            $display("FAIL backpressure: vld=%b rdy=%b q=%h r=%h required 1/0/%h/%h",
                     rsp_valid, req_ready, rsp_quotient, rsp_remainder, a / b, a % b);
        end
        consume();
        compared++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL backpressure_release: vld=%b rdy=%b required 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid();
        bit ok_req, seen;
        clear_log();
        send_req(16'd25, 16'd5, ok_req);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (start_data && tx_log.size() == 2) seen = 1'b1;
            else tick();
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if (!seen || {start_data, received_data, busy, req_ready, rsp_valid, bus_out} !== '0) begin
            mismatched++;
            $display("FAIL reset_mid: seen=%b sd=%b rd=%b busy=%b rdy=%b vld=%b bus=%h required 0",
                     seen, start_data, received_data, busy, req_ready, rsp_valid, bus_out);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_txn("after_reset_25_5", 16'd25, 16'd5);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = (i % 2 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
            run_txn("random", a, b);
        end
    endtask

    task automatic test_zero_divisor();
        bit ok_req, ok_rsp;
        logic [15:0] q, r;
        logic dz;
        clear_log();
        send_req(16'd77, 16'd0, ok_req);
        wait_rsp(ok_rsp, q, r, dz);
`ifdef DIV_BUS_HOST_ZERO_CHECK_EN
        compared++;
        if (!ok_rsp || tx_log.size() != 0 || {q, r, dz} !== {16'hFFFF, 16'd77, 1'b1}) begin
            mismatched++;
            $display("FAIL zero_check: bytes=%0d q=%h r=%h dz=%b required 0/ffff/004d/1",
                     tx_log.size(), q, r, dz);
        end
`else
        compared++;
        if (!ok_rsp || tx_log.size() != 4 || {q, r, dz} !== {16'hFFFF, 16'd77, 1'b0}) begin
            mismatched++;
            $display("FAIL zero_passthru: bytes=%0d q=%h r=%h dz=%b required 4/ffff/004d/0",
                     tx_log.size(), q, r, dz);
        end
`endif
        consume();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rx_acks();
        test_tx_stall();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_zero_divisor();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
